// File: rtl/charlieplex_keyscan.sv
// Charlieplexed key-matrix scanner: drives one pin low at a time, samples
// the rest and streams key press/release events on a valid/ready port.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   enable          scan enable, checked only at the end of a phase
//   in              raw pulled-up pad inputs (asynchronous)
//   out_en          pad output enable, one-hot while scanning, else 0
//   out_value       pad output value, tied low
//   event_valid     event pending
//   event_ready     consumer accepts the pending event
//   event_index     key index of the pending event
//   event_pressed   1 = press, 0 = release
//   key_state       current scanned key state, 1 = pressed
module charlieplex_keyscan #(
   parameter int PINCOUNT      = 4,
   parameter int SETTLE_CYCLES = 8,
   parameter int INDEXBITS     = $clog2(PINCOUNT*(PINCOUNT-1))
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic [PINCOUNT-1:0]              in,
   output logic [PINCOUNT-1:0]              out_en,
   output logic [PINCOUNT-1:0]              out_value,
   output logic                             event_valid,
   input  logic                             event_ready,
   output logic [INDEXBITS-1:0]             event_index,
   output logic                             event_pressed,
   output logic [PINCOUNT*(PINCOUNT-1)-1:0] key_state
);

   localparam int NKEYS = PINCOUNT*(PINCOUNT-1);
   localparam int PW    = $clog2(PINCOUNT);
   localparam int CW    = $clog2(SETTLE_CYCLES+1);

   localparam logic [PW-1:0] PMAX = PW'(PINCOUNT-1);
   localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYCLES-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_COMPARE,
      S_WAIT
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        d_q, d_d;
   logic [PW-1:0]        s_q, s_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PINCOUNT-1:0]  sync1_q, sync1_d;
   logic [PINCOUNT-1:0]  sync2_q, sync2_d;
   logic [PINCOUNT-1:0]  sample_q, sample_d;
   logic [PINCOUNT-1:0]  out_en_q, out_en_d;
   logic                 ev_valid_q, ev_valid_d;
   logic [INDEXBITS-1:0] ev_index_q, ev_index_d;
   logic                 ev_pressed_q, ev_pressed_d;
   logic [NKEYS-1:0]     ks_q, ks_d;

   logic [INDEXBITS-1:0] k;
   logic                 pressed;
   logic                 last_s;
   logic                 phase_end;
   logic [PW-1:0]        d_next;

   // Sense pins below the drive pin keep their number, those above
   // shift down by one, so every drive pin owns PINCOUNT-1 slots.
   function automatic logic [INDEXBITS-1:0] key_idx(
      input logic [PW-1:0] dv,
      input logic [PW-1:0] sv
   );
      int idx;
      idx = int'(dv) * (PINCOUNT-1)
          + ((sv < dv) ? int'(sv) : int'(sv) - 1);
      return INDEXBITS'(idx);
   endfunction

   always_comb begin
      state_d      = state_q;
      d_d          = d_q;
      s_d          = s_q;
      cnt_d        = cnt_q;
      sample_d     = sample_q;
      out_en_d     = out_en_q;
      ev_valid_d   = ev_valid_q;
      ev_index_d   = ev_index_q;
      ev_pressed_d = ev_pressed_q;
      ks_d         = ks_q;
      sync1_d      = in;
      sync2_d      = sync1_q;

      k         = key_idx(d_q, s_q);
      pressed   = ~sample_q[s_q];
      last_s    = (s_q == PMAX);
      d_next    = (d_q == PMAX) ? '0 : d_q + PW'(1);
      phase_end = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d  = S_DRIVE;
               d_d      = '0;
               cnt_d    = '0;
               out_en_d = PINCOUNT'(1);
            end
         end
         S_DRIVE: begin
            if (cnt_q == CMAX) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SAMPLE: begin
            sample_d = sync2_q;
            s_d      = '0;
            state_d  = S_COMPARE;
         end
         S_COMPARE: begin
            if (s_q != d_q && pressed != ks_q[k]) begin
               ev_valid_d   = 1'b1;
               ev_index_d   = k;
               ev_pressed_d = pressed;
               state_d      = S_WAIT;
            end else if (last_s) begin
               phase_end = 1'b1;
            end else begin
               s_d = s_q + PW'(1);
            end
         end
         S_WAIT: begin
            if (ev_valid_q && event_ready) begin
               ks_d[ev_index_q] = ev_pressed_q;
               ev_valid_d       = 1'b0;
               if (last_s) begin
                  phase_end = 1'b1;
               end else begin
                  s_d     = s_q + PW'(1);
                  state_d = S_COMPARE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Next drive pin is selected here so out_en changes on the same
      // edge that closes the phase.
      if (phase_end) begin
         d_d = d_next;
         s_d = '0;
         if (enable) begin
            state_d  = S_DRIVE;
            cnt_d    = '0;
            out_en_d = PINCOUNT'(1) << d_next;
         end else begin
            state_d  = S_IDLE;
            out_en_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         d_q          <= '0;
         s_q          <= '0;
         cnt_q        <= '0;
         sync1_q      <= '1;
         sync2_q      <= '1;
         sample_q     <= '1;
         out_en_q     <= '0;
         ev_valid_q   <= 1'b0;
         ev_index_q   <= '0;
         ev_pressed_q <= 1'b0;
         ks_q         <= '0;
      end else begin
         state_q      <= state_d;
         d_q          <= d_d;
         s_q          <= s_d;
         cnt_q        <= cnt_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sample_q     <= sample_d;
         out_en_q     <= out_en_d;
         ev_valid_q   <= ev_valid_d;
         ev_index_q   <= ev_index_d;
         ev_pressed_q <= ev_pressed_d;
         ks_q         <= ks_d;
      end
   end

   assign out_en        = out_en_q;
   assign out_value     = '0;
   assign event_valid   = ev_valid_q;
   assign event_index   = ev_index_q;
   assign event_pressed = ev_pressed_q;
   assign key_state     = ks_q;

endmodule

// File: tb/tb_charlieplex_keyscan.sv
// Bench for charlieplex_keyscan: pad pull-up model, key matrix model and
// an event scoreboard derived from per-phase key differences.
module tb_charlieplex_keyscan;

   localparam int P  = 4;
   localparam int SC = 4;
   localparam int NK = P*(P-1);
   localparam int IB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic          event_ready = 1'b0;
   logic [P-1:0]  in;
   logic [P-1:0]  out_en;
   logic [P-1:0]  out_value;
   logic          event_valid;
   logic [IB-1:0] event_index;
   logic          event_pressed;
   logic [NK-1:0] key_state;

   charlieplex_keyscan #(
      .PINCOUNT     (P),
      .SETTLE_CYCLES(SC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .in           (in),
      .out_en       (out_en),
      .out_value    (out_value),
      .event_valid  (event_valid),
      .event_ready  (event_ready),
      .event_index  (event_index),
      .event_pressed(event_pressed),
      .key_state    (key_state)
   );

   always #5 clk = ~clk;

   bit phys [P][P];
   bit pend [P][P];
   int kidx [P][P];

   bit mks  [NK];
   bit proj [NK];
   int expq [$];
   int acc_log [$];

   int n_tests = 0;
   int n_fail  = 0;
   int hold    = 0;
   bit ph_ev   = 1'b1;
   int exp_d   = 0;
   int phases  = 0;
   int last_k  = -1;
   int last_p  = -1;

   // A driven pin reads low; a pressed key (d,s) pulls s low while d drives.
   always_comb begin
      in = '1;
      for (int d = 0; d < P; d++) begin
         if (out_en[d]) begin
            in[d] = 1'b0;
            for (int s = 0; s < P; s++)
               if (phys[d][s]) in[s] = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NK-1:0] pack_mks();
      logic [NK-1:0] v;
      for (int i = 0; i < NK; i++) v[i] = mks[i];
      return v;
   endfunction

   function automatic logic [NK-1:0] pack_phys();
      logic [NK-1:0] v;
      v = '0;
      for (int d = 0; d < P; d++)
         for (int s = 0; s < P; s++)
            if (s != d) v[kidx[d][s]] = phys[d][s];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NK; i++) begin
         mks[i]  = 1'b0;
         proj[i] = 1'b0;
      end
      expq.delete();
      hold  = 0;
      ph_ev = 1'b1;
      exp_d = 0;
   endtask

   task automatic tick();
      logic          acc, pvalid, ppr;
      logic [IB-1:0] pidx;
      logic [P-1:0]  pen;
      int            d, e;
      bit            any;
      acc    = event_valid && event_ready;
      pvalid = event_valid;
      pidx   = event_index;
      ppr    = event_pressed;
      pen    = out_en;
      @(posedge clk);
      #1;
      if (acc) begin
         if (expq.size() == 0) begin
            check("unexpected_event", 1, 0);
         end else begin
            e = expq.pop_front();
            check("ev_index", 32'(pidx), e / 2);
            check("ev_pressed", 32'(ppr), e % 2);
            mks[e/2] = bit'(e % 2);
         end
         last_k = int'(pidx);
         last_p = int'(ppr);
         acc_log.push_back(int'(pidx));
      end else if (pvalid) begin
         check("valid_held", 32'(event_valid), 1);
         check("index_stable", 32'(event_index), 32'(pidx));
         check("pressed_stable", 32'(event_pressed), 32'(ppr));
      end
      check("key_state", 32'(key_state), 32'(pack_mks()));
      check("out_value", 32'(out_value), 0);
      check("out_en_onehot0", 32'($onehot0(out_en)), 1);
      if (out_en != pen) begin
         if (pen != 0 && !ph_ev) check("phase_len", hold, SC + 1 + P);
         hold = 1;
         if (out_en != 0) begin
            d = $clog2(out_en);
            check("phase_d", d, exp_d);
            check("prev_phase_drained", expq.size(), 0);
            exp_d = (d + 1) % P;
            phases++;
            phys = pend;
            any  = 1'b0;
            for (int s = 0; s < P; s++) begin
               if (s != d && phys[d][s] != proj[kidx[d][s]]) begin
                  expq.push_back(kidx[d][s] * 2 + int'(phys[d][s]));
                  proj[kidx[d][s]] = phys[d][s];
                  any = 1'b1;
               end
            end
            ph_ev = any;
         end else begin
            exp_d = 0;
         end
      end else begin
         hold++;
      end
   endtask

   task automatic run(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         if (rnd) event_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
   endtask

   task automatic wait_valid(input int max);
      int n;
      n = 0;
      while (!event_valid && n < max) begin
         tick();
         n++;
      end
      check("wait_valid_timeout", 32'(event_valid), 1);
   endtask

   task automatic clear_keys();
      for (int d = 0; d < P; d++)
         for (int s = 0; s < P; s++)
            pend[d][s] = 1'b0;
   endtask

   initial begin
      int n;
      n = 0;
      for (int d = 0; d < P; d++)
         for (int s = 0; s < P; s++)
            if (s != d) begin
               kidx[d][s] = n;
               n++;
            end
      clear_keys();
      phys = pend;
      model_reset();

      // reset state
      #1 rst_n = 1'b0;
      tick();
      tick();
      check("rst_out_en", 32'(out_en), 0);
      check("rst_event_valid", 32'(event_valid), 0);
      check("rst_event_index", 32'(event_index), 0);
      check("rst_event_pressed", 32'(event_pressed), 0);
      check("rst_key_state", 32'(key_state), 0);

      // idle scanning
      enable      = 1'b1;
      event_ready = 1'b1;
      rst_n       = 1'b1;
      tick();
      check("first_drive", 32'(out_en), 1);
      phases = 1;
      run(115, 1'b0);
      check("idle_phases", 32'(phases >= 12), 1);
      check("idle_no_events", acc_log.size(), 0);

      // press and release key (2,0)
      pend[2][0] = 1'b1;
      run(80, 1'b0);
      check("press_k", last_k, 6);
      check("press_p", last_p, 1);
      check("press_ks6", 32'(key_state[6]), 1);
      pend[2][0] = 1'b0;
      run(80, 1'b0);
      check("release_k", last_k, 6);
      check("release_p", last_p, 0);
      check("press_release_count", acc_log.size(), 2);

      // backpressure on key (1,3)
      event_ready = 1'b0;
      pend[1][3]  = 1'b1;
      wait_valid(100);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_valid", 32'(event_valid), 1);
         check("bp_index", 32'(event_index), 5);
         check("bp_pressed", 32'(event_pressed), 1);
         check("bp_out_en", 32'(out_en), 32'h2);
         check("bp_ks5", 32'(key_state[5]), 0);
      end
      event_ready = 1'b1;
      tick();
      check("bp_accept_valid", 32'(event_valid), 0);
      check("bp_accept_ks5", 32'(key_state[5]), 1);
      check("bp_accept_k", last_k, 5);

      // two changes in one phase
      pend[1][3] = 1'b0;
      run(80, 1'b0);
      acc_log.delete();
      pend[1][0] = 1'b1;
      pend[1][3] = 1'b1;
      run(80, 1'b0);
      check("multi_count", acc_log.size(), 2);
      if (acc_log.size() >= 2) begin
         check("multi_first", acc_log[0], 3);
         check("multi_second", acc_log[1], 5);
      end
      run(80, 1'b0);
      check("multi_no_dup", acc_log.size(), 2);

      // reset while an event waits
      clear_keys();
      run(80, 1'b0);
      event_ready = 1'b0;
      pend[3][1]  = 1'b1;
      wait_valid(100);
      check("pre_rst_index", 32'(event_index), 10);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_en", 32'(out_en), 0);
      check("mid_rst_valid", 32'(event_valid), 0);
      check("mid_rst_index", 32'(event_index), 0);
      check("mid_rst_pressed", 32'(event_pressed), 0);
      check("mid_rst_key_state", 32'(key_state), 0);
      model_reset();
      tick();
      tick();
      event_ready = 1'b1;
      rst_n       = 1'b1;
      acc_log.delete();
      run(80, 1'b0);
      check("rst_rereport_count", acc_log.size(), 1);
      check("rst_rereport_k", last_k, 10);
      check("rst_rereport_p", last_p, 1);

      // drop enable with an event pending in phase d=1
      clear_keys();
      run(80, 1'b0);
      event_ready = 1'b0;
      pend[1][2]  = 1'b1;
      wait_valid(100);
      check("drop_out_en", 32'(out_en), 32'h2);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("drop_valid_kept", 32'(event_valid), 1);
      event_ready = 1'b1;
      acc_log.delete();
      run(20, 1'b0);
      check("drop_idle_out_en", 32'(out_en), 0);
      check("drop_k", last_k, 4);
      check("drop_p", last_p, 1);
      run(20, 1'b0);
      check("drop_idle_quiet", acc_log.size(), 1);
      check("drop_idle_valid", 32'(event_valid), 0);
      enable = 1'b1;
      tick();
      check("reenable_out_en", 32'(out_en), 1);

      // randomized key patterns with random backpressure
      for (int r = 0; r < 6; r++) begin
         for (int d = 0; d < P; d++)
            for (int s = 0; s < P; s++)
               if (s != d && $urandom_range(0, 3) == 0)
                  pend[d][s] = !pend[d][s];
         run(100, 1'b1);
         event_ready = 1'b1;
         run(120, 1'b0);
         check("rand_drained", expq.size(), 0);
         check("rand_state", 32'(key_state), 32'(pack_phys()));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
